// File: rtl/spio_aer_in_buffer.sv
// spio_aer_in_buffer
//   Front end of the AER-to-SpiNNaker mapper. Accepts events from an
//   asynchronous AER sensor (4-phase, active-low req/ack) and synchronises
//   its request into clk. Events are buffered in a small circular FIFO and
//   replayed to the mapper over a synchronous 4-phase active-low handshake.
//   The FIFO decouples sensor ack latency from mapper back-pressure.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active high
//   ext_aer_data  sensor event data (bundled with ext_aer_req)
//   ext_aer_req   sensor request, active low, asynchronous
//   ext_aer_ack   sensor acknowledge, active low, registered
//   iaer_data     event data to mapper, registered
//   iaer_req      request to mapper, active low, registered
//   iaer_ack      acknowledge from mapper, active low, synchronous
//   fifo_count    current FIFO occupancy
//   drop_count    discarded-event counter (only with SPIO_AER_IN_DROP_EN)
//
// Build option
//   SPIO_AER_IN_DROP_EN: when defined, an event arriving while the FIFO is
//   full is acknowledged and discarded instead of stalling the sensor.
module spio_aer_in_buffer #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              ext_aer_data,
    input  logic                     ext_aer_req,
    output logic                     ext_aer_ack,
    output logic [15:0]              iaer_data,
    output logic                     iaer_req,
    input  logic                     iaer_ack,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
`ifdef SPIO_AER_IN_DROP_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {E_IDLE, E_WAIT} e_state_t;
    typedef enum logic [1:0] {I_IDLE, I_REQ, I_REL} i_state_t;

    logic [SYNC_STAGES-1:0]     sync_q, sync_d;
    e_state_t                   e_state_q, e_state_d;
    i_state_t                   i_state_q, i_state_d;
    logic                       ext_ack_q, ext_ack_d;
    logic                       iaer_req_q, iaer_req_d;
    logic [15:0]                iaer_data_q, iaer_data_d;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic [15:0]                mem_q [DEPTH];
`ifdef SPIO_AER_IN_DROP_EN
    logic [15:0]                drop_cnt_q, drop_cnt_d;
`endif

    logic req_s;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign req_s = sync_q[SYNC_STAGES-1];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], ext_aer_req};
        e_state_d   = e_state_q;
        i_state_d   = i_state_q;
        ext_ack_d   = ext_ack_q;
        iaer_req_d  = iaer_req_q;
        iaer_data_d = iaer_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        push        = 1'b0;
        pop         = 1'b0;
`ifdef SPIO_AER_IN_DROP_EN
        drop_cnt_d  = drop_cnt_q;
`endif

        // Sensor side: one push per completed 4-phase handshake.
        case (e_state_q)
            E_IDLE: begin
                if (!req_s) begin
                    if (!full) begin
                        push      = 1'b1;
                        ext_ack_d = 1'b0;
                        e_state_d = E_WAIT;
                    end
`ifdef SPIO_AER_IN_DROP_EN
                    else begin
                        ext_ack_d = 1'b0;
                        e_state_d = E_WAIT;
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                    end
`endif
                end
            end
            E_WAIT: begin
                if (req_s) begin
                    ext_ack_d = 1'b1;
                    e_state_d = E_IDLE;
                end
            end
            default: e_state_d = E_IDLE;
        endcase

        // Mapper side: head is loaded on request, popped on acknowledge.
        case (i_state_q)
            I_IDLE: begin
                if (!empty && iaer_ack) begin
                    iaer_data_d = mem_q[rd_ptr_q];
                    iaer_req_d  = 1'b0;
                    i_state_d   = I_REQ;
                end
            end
            I_REQ: begin
                if (!iaer_ack) begin
                    pop        = 1'b1;
                    iaer_req_d = 1'b1;
                    i_state_d  = I_REL;
                end
            end
            I_REL: begin
                if (iaer_ack) begin
                    i_state_d = I_IDLE;
                end
            end
            default: i_state_d = I_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '1;
            e_state_q   <= E_IDLE;
            i_state_q   <= I_IDLE;
            ext_ack_q   <= 1'b1;
            iaer_req_q  <= 1'b1;
            iaer_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef SPIO_AER_IN_DROP_EN
            drop_cnt_q  <= '0;
`endif
        end else begin
            sync_q      <= sync_d;
            e_state_q   <= e_state_d;
            i_state_q   <= i_state_d;
            ext_ack_q   <= ext_ack_d;
            iaer_req_q  <= iaer_req_d;
            iaer_data_q <= iaer_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`ifdef SPIO_AER_IN_DROP_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    // Storage is not reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ext_aer_data;
        end
    end

    assign ext_aer_ack = ext_ack_q;
    assign iaer_req    = iaer_req_q;
    assign iaer_data   = iaer_data_q;
    assign fifo_count  = count_q;
`ifdef SPIO_AER_IN_DROP_EN
    assign drop_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spio_aer_in_buffer.sv
module tb_spio_aer_in_buffer;

    localparam int DEPTH = 16;
    localparam int SYNC  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ext_aer_data = '0;
    logic        ext_aer_req = 1'b1;
    logic        ext_aer_ack;
    logic [15:0] iaer_data;
    logic        iaer_req;
    logic        iaer_ack;
    logic [4:0]  fifo_count;
`ifdef SPIO_AER_IN_DROP_EN
    logic [15:0] drop_count;
`endif

    logic auto_ack   = 1'b1;
    logic man_ack    = 1'b1;
    logic map_manual = 1'b0;
    logic map_stall  = 1'b0;
    assign iaer_ack = map_manual ? man_ack : auto_ack;

    spio_aer_in_buffer #(.FIFO_DEPTH_LOG2(4), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .ext_aer_data (ext_aer_data),
        .ext_aer_req  (ext_aer_req),
        .ext_aer_ack  (ext_aer_ack),
        .iaer_data    (iaer_data),
        .iaer_req     (iaer_req),
        .iaer_ack     (iaer_ack),
        .fifo_count   (fifo_count)
`ifdef SPIO_AER_IN_DROP_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a queue of accepted events, an occupancy
    // count, and the sequence of events seen by the mapper.
    logic [15:0] exp_q[$];
    logic [15:0] got[$];
    logic [15:0] sent_data = '0;
    logic [15:0] held = '0;
    int          mcnt = 0;
    int          mdrops = 0;
    logic        prev_ack = 1'b1;
    logic        prev_req = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mcnt     = 0;
            mdrops   = 0;
            prev_ack = 1'b1;
            prev_req = 1'b1;
        end else begin
            if (prev_ack && !ext_aer_ack) begin
                if (mcnt < DEPTH) begin
                    exp_q.push_back(sent_data);
                    mcnt++;
                end else begin
`ifdef SPIO_AER_IN_DROP_EN
                    if (mdrops < 65535) mdrops++;
`else
                    chk("ack_while_full", mcnt, DEPTH - 1);
`endif
                end
            end
            if (prev_req && !iaer_req) begin
                if (exp_q.size() == 0) chk("req_without_event", 0, 1);
                else chk("iaer_data_head", iaer_data, exp_q[0]);
                held = iaer_data;
            end else if (!prev_req && !iaer_req) begin
                chk("iaer_data_stable", iaer_data, held);
            end
            if (!prev_req && iaer_req) begin
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    mcnt--;
                end
                got.push_back(held);
            end
            chk("fifo_count", fifo_count, mcnt);
`ifdef SPIO_AER_IN_DROP_EN
            chk("drop_count", drop_count, mdrops);
`endif
            prev_ack = ext_aer_ack;
            prev_req = iaer_req;
        end
    end

    // Mapper: acks one negedge after request, releases after request rises.
    always @(negedge clk) begin
        if (!map_manual && !rst) begin
            if (auto_ack && !iaer_req && !map_stall) auto_ack = 1'b0;
            else if (!auto_ack && iaer_req) auto_ack = 1'b1;
        end
    end

    task automatic wait_ack(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ext_aer_ack === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ev_start(input logic [15:0] d);
        @(negedge clk);
        ext_aer_data = d;
        sent_data    = d;
        ext_aer_req  = 1'b0;
    endtask

    task automatic ev_finish();
        bit ok;
        if (ext_aer_ack !== 1'b0) begin
            wait_ack(1'b0, 60, ok);
            chk("sensor_ack_fall_timeout", ok, 1);
        end
        ext_aer_req = 1'b1;
        wait_ack(1'b1, 60, ok);
        chk("sensor_ack_rise_timeout", ok, 1);
    endtask

    task automatic send_event(input logic [15:0] d);
        ev_start(d);
        ev_finish();
    endtask

    task automatic wait_delivered(input int n);
        for (int i = 0; i < 2000 && got.size() < n; i++) @(negedge clk);
        chk("delivered_count", got.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected end", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ack_edge;
        int req_edge;
        bit ok;

        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        chk("rst_ext_aer_ack", ext_aer_ack, 1);
        chk("rst_iaer_req", iaer_req, 1);
        chk("rst_iaer_data", iaer_data, 0);
        chk("rst_fifo_count", fifo_count, 0);
`ifdef SPIO_AER_IN_DROP_EN
        chk("rst_drop_count", drop_count, 0);
`endif

        // Single event latency.
        base = got.size();
        ack_edge = 0;
        req_edge = 0;
        ev_start(16'hA5C3);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (ack_edge == 0 && !ext_aer_ack) ack_edge = k;
            if (req_edge == 0 && !iaer_req) begin
                req_edge = k;
                chk("t1_iaer_data", iaer_data, 16'hA5C3);
            end
        end
        chk("t1_ack_latency", ack_edge, SYNC + 1);
        chk("t1_req_latency", req_edge, SYNC + 2);
        @(negedge clk);
        ext_aer_req = 1'b1;
        wait_ack(1'b1, SYNC + 3, ok);
        chk("t1_ack_release", ok, 1);
        wait_delivered(base + 1);
        chk("t1_got", got[base], 16'hA5C3);
        chk("t1_fifo_empty", fifo_count, 0);

        // Fill with mapper stalled.
        map_stall = 1'b1;
        base = got.size();
`ifdef SPIO_AER_IN_DROP_EN
        for (int i = 0; i < 20; i++) send_event(16'(i));
        chk("t2_drop_count", drop_count, 4);
        chk("t2_full_count", fifo_count, 16);
        map_stall = 1'b0;
        wait_delivered(base + 16);
        for (int i = 0; i < 16; i++) chk("t2_order", got[base + i], i);
`else
        for (int i = 0; i < 16; i++) send_event(16'(i));
        ev_start(16'd16);
        repeat (10) @(negedge clk);
        chk("t2_stall_ack", ext_aer_ack, 1);
        chk("t2_full_count", fifo_count, 16);
        map_stall = 1'b0;
        ev_finish();
        for (int i = 17; i < 20; i++) send_event(16'(i));
        wait_delivered(base + 20);
        for (int i = 0; i < 20; i++) chk("t2_order", got[base + i], i);
`endif
        repeat (5) @(negedge clk);

        // Push and pop on the same edge at occupancy 5.
        map_stall = 1'b1;
        base = got.size();
        for (int i = 0; i < 5; i++) send_event(16'h0300 + 16'(i));
        chk("t3_pre_count", fifo_count, 5);
        chk("t3_pre_req", iaer_req, 0);
        map_manual = 1'b1;
        ev_start(16'h0305);
        @(negedge clk);
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
        chk("t3_same_edge_count", fifo_count, 5);
        chk("t3_same_edge_ack", ext_aer_ack, 0);
        chk("t3_same_edge_req", iaer_req, 1);
        man_ack = 1'b1;
        @(negedge clk);
        map_manual = 1'b0;
        map_stall  = 1'b0;
        ev_finish();
        wait_delivered(base + 6);
        chk("t3_next_head", got[base + 1], 16'h0301);
        for (int i = 0; i < 6; i++) chk("t3_order", got[base + i], 16'h0300 + 16'(i));

        // Pointer wrap with continuous draining.
        base = got.size();
        for (int i = 0; i < 40; i++) send_event(16'(i));
        wait_delivered(base + 40);
        for (int i = 0; i < 40; i++) chk("t4_order", got[base + i], i);

        // Asynchronous reset mid-handshake.
        map_stall = 1'b1;
        ev_start(16'hBEEF);
        wait_ack(1'b0, 20, ok);
        chk("t5_ack_timeout", ok, 1);
        @(negedge clk);
        @(negedge clk);
        chk("t5_pre_req", iaer_req, 0);
        chk("t5_pre_ack", ext_aer_ack, 0);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_ext_aer_ack", ext_aer_ack, 1);
        chk("t5_rst_iaer_req", iaer_req, 1);
        chk("t5_rst_iaer_data", iaer_data, 0);
        chk("t5_rst_fifo_count", fifo_count, 0);
        ext_aer_req = 1'b1;
        map_stall   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b0;
        base = got.size();
        send_event(16'h5A5A);
        wait_delivered(base + 1);
        chk("t5_after_rst", got[base], 16'h5A5A);
        repeat (4) @(negedge clk);
        chk("t5_final_count", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spio_aer_in_buffer.md
Name: spio_aer_in_buffer

Overview:
- Upstream front end of the AER-to-SpiNNaker mapper.
- Accepts events from an external asynchronous AER sensor using a 4-phase, active-low req/ack handshake, and synchronises req into the clk domain.
- Stores events in a small FIFO.
- Replays events to the mapper over the mapper's synchronous 4-phase active-low iaer_req/iaer_ack interface.
- Decouples sensor ack latency from mapper/packet back-pressure.

Parameters:
- FIFO_DEPTH_LOG2, 4, log2 of FIFO depth in 16-bit events (depth = 16).
- SYNC_STAGES, 2, flip-flop stages on ext_aer_req (minimum 2).

Ports:
- clk  input  1  system clock; single clock domain for the whole block.
- rst  input  1  asynchronous reset, active-high.
- ext_aer_data  input  16  event data from sensor; bundled, stable from req fall until ack fall.
- ext_aer_req  input  1  sensor request, active LOW, asynchronous to clk.
- ext_aer_ack  output  1  sensor acknowledge, active LOW, registered.
- iaer_data  output  16  event data to mapper, registered.
- iaer_req  output  1  request to mapper, active LOW, registered.
- iaer_ack  input  1  acknowledge from mapper, active LOW, synchronous to clk.
- fifo_count  output  FIFO_DEPTH_LOG2+1  current occupancy (status only).

Behaviour:
- Reset (async, rst=1):
  - ext_aer_ack=1, iaer_req=1, iaer_data=0, fifo_count=0, both FSMs idle, synchroniser flops=1.
  - Reset mid-handshake abandons the transaction; FIFO contents are lost.
- Synchroniser: req_s = ext_aer_req delayed through SYNC_STAGES flops, reset to 1. ext_aer_data is not synchronised; bundled-data timing guarantees it is stable when req_s is sampled low.
- External FSM (E_IDLE, E_WAIT):
  - E_IDLE, req_s=0 and FIFO not full: on that edge, push ext_aer_data, drive ext_aer_ack<=0, go to E_WAIT.
  - E_IDLE, req_s=0 and FIFO full: stall; ack stays 1, no push.
  - E_WAIT, req_s=1: drive ext_aer_ack<=1, go to E_IDLE.
  - Exactly one push per external handshake.
- Internal FSM (I_IDLE, I_REQ, I_REL):
  - I_IDLE, FIFO not empty and iaer_ack=1: iaer_data<=head, iaer_req<=0, go to I_REQ.
  - I_REQ, iaer_ack=0: pop head, iaer_req<=1, go to I_REL.
  - I_REL, iaer_ack=1: go to I_IDLE.
  - iaer_data holds stable from the req-assert edge until the next I_IDLE load.
  - Minimum spacing between iaer_req assertions is 3 cycles.
- FIFO:
  - Registered, power-of-two circular buffer; pointers are FIFO_DEPTH_LOG2 bits and wrap naturally.
  - full = (count == 2^FIFO_DEPTH_LOG2), empty = (count == 0).
  - Simultaneous push and pop: count unchanged, both pointers advance. Push while full is impossible by construction.
  - A push becomes visible to I_IDLE the cycle after the push edge.
- Latency, ext req fall to iaer_req fall with FIFO empty and mapper idle: SYNC_STAGES+2 clk edges (±1 for async sampling).
- Ordering: strict FIFO order; no event is reordered or duplicated.

Optional Feature:
- Macro: SPIO_AER_IN_DROP_EN.
- Defined:
  - When E_IDLE sees req_s=0 with FIFO full, the event is discarded: ext_aer_ack<=0, go to E_WAIT, no push.
  - The sensor is never stalled.
  - Adds output drop_count [15:0], reset 0, +1 per discarded event, saturating at 16'hFFFF.
- Not defined: full FIFO stalls the sensor as above; drop_count port is absent.

Test Plan:
- Single event 16'hA5C3, mapper acks 1 cycle after iaer_req:
  - ext_aer_ack falls SYNC_STAGES+1 edges after req fall and rises after req release.
  - iaer_data=16'hA5C3 with iaer_req low.
  - fifo_count returns to 0.
- 20 back-to-back sensor events (data 0..19), mapper ack held high (stalled):
  - 16 events acked; 17th stalls with ext_aer_ack=1 and fifo_count=16.
  - After mapper releases, all 20 delivered in order 0..19.
- Mapper ack and sensor push on the same edge with fifo_count=5: fifo_count stays 5; the next event delivered is the correct FIFO head.
- 40 events through depth-16 FIFO with continuous draining: pointers wrap at least twice, sequence 0..39 is intact, no duplicates.
- rst pulse while iaer_req=0 and ext_aer_ack=0: all outputs return to reset values immediately (async); fifo_count=0; a new event afterwards is delivered normally.
- With SPIO_AER_IN_DROP_EN defined, 20 events and mapper stalled: all 20 are acked, drop_count=4, and events 0..15 are delivered after release.
